adc_sar_controller: RTL and testbench



---
 rtl/adc_sar_pkg.sv | 18 +
 rtl/adc_sar_delay_cnt.sv | 30 +++
 rtl/adc_sar_controller.sv | 188 ++++++++++++++++++
 tb/tb_adc_sar_controller.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_sar_pkg.sv
// Shared types and constants for the 12-bit SAR ADC sequencer.
package adc_sar_pkg;

  localparam int RES_BITS       = 12;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int CNT_W          = 8;

  localparam logic [RES_BITS-1:0] MIDSCALE = 12'h800;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/adc_sar_delay_cnt.sv
// Loadable down-counter with a terminal flag. One instance covers the
// sample, settle and comparator-timeout intervals, which never overlap.
module adc_sar_delay_cnt
  import adc_sar_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             term_o
);

  logic [CNT_W-1:0] count_q;

  // Load has priority over decrement; the counter rests at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - CNT_W'(1);
    end
  end

  // Terminal on the last cycle of an interval loaded with N (N >= 1).
  assign term_o = (count_q <= CNT_W'(1));

endmodule

// File: rtl/adc_sar_controller.sv
// Successive-approximation sequencer: sample phase, then 12 MSB-first
// trials with a clocked comparator handshake and a forced-zero timeout.
module adc_sar_controller
  import adc_sar_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [7:0]          cfg_sample_cycles,
  input  logic [1:0]          cfg_settle_cycles,
  input  logic                comp_done,
  input  logic                comp_result,
  output logic                sample_en,
  output logic [RES_BITS-1:0] dac_code,
  output logic                comp_trig,
  output logic                busy,
  output logic [RES_BITS-1:0] result,
  output logic                result_valid,
  output logic                overrun_err,
  output logic                timeout_err
);

  state_e              state_q;
  logic [3:0]          bit_idx_q;
  logic [1:0]          settle_q;
  logic [RES_BITS-1:0] dac_code_q;
  logic [RES_BITS-1:0] result_q;
  logic                sample_en_q;
  logic                comp_trig_q;
  logic                busy_q;
  logic                result_valid_q;
  logic                overrun_q;
  logic                timeout_q;

  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_term;
  logic             decide;
  logic [RES_BITS-1:0] code_decided;

  adc_sar_delay_cnt u_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (cnt_val),
    .term_o     (cnt_term)
  );

  // A trial resolves on the first comp_done after the trigger cycle, or on
  // timeout; comp_done in the trigger cycle itself is never accepted.
  assign decide = (state_q == ST_COMPARE) && !comp_trig_q && (comp_done || cnt_term);

  // Current trial bit is kept only on a real comparator "above" decision.
  assign code_decided = (comp_done && comp_result) ? dac_code_q
                        : (dac_code_q & ~(RES_BITS'(1) << bit_idx_q));

  // Counter control: load at the start of each interval, count down inside it.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_load = 1'b1;
          cnt_val  = (cfg_sample_cycles == 8'd0) ? 8'd1 : cfg_sample_cycles;
        end
      end
      ST_SAMPLE: begin
        if (!cnt_term) begin
          cnt_dec = 1'b1;
        end else if (settle_q != 2'd0) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(settle_q);
        end
      end
      ST_SETTLE: begin
        cnt_dec = !cnt_term;
      end
      ST_COMPARE: begin
        if (comp_trig_q) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(TIMEOUT_CYCLES);
        end else if (decide && (bit_idx_q != 4'd0) && (settle_q != 2'd0)) begin
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(settle_q);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Main sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      bit_idx_q      <= '0;
      settle_q       <= '0;
      dac_code_q     <= '0;
      result_q       <= '0;
      sample_en_q    <= 1'b0;
      comp_trig_q    <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      comp_trig_q    <= 1'b0;
      result_valid_q <= 1'b0;
      if (start && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          dac_code_q <= '0;
          if (start) begin
            state_q     <= ST_SAMPLE;
            settle_q    <= cfg_settle_cycles;
            sample_en_q <= 1'b1;
            busy_q      <= 1'b1;
            overrun_q   <= 1'b0;
            timeout_q   <= 1'b0;
          end
        end
        ST_SAMPLE: begin
          if (cnt_term) begin
            sample_en_q <= 1'b0;
            dac_code_q  <= MIDSCALE;
            bit_idx_q   <= 4'(RES_BITS - 1);
            if (settle_q != 2'd0) begin
              state_q <= ST_SETTLE;
            end else begin
              state_q     <= ST_COMPARE;
              comp_trig_q <= 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt_term) begin
            state_q     <= ST_COMPARE;
            comp_trig_q <= 1'b1;
          end
        end
        ST_COMPARE: begin
          if (decide) begin
            if (!comp_done) begin
              timeout_q <= 1'b1;
            end
            if (bit_idx_q == 4'd0) begin
              state_q        <= ST_DONE;
              dac_code_q     <= code_decided;
              result_q       <= code_decided;
              result_valid_q <= 1'b1;
            end else begin
              dac_code_q <= code_decided | (RES_BITS'(1) << (bit_idx_q - 4'd1));
              bit_idx_q  <= bit_idx_q - 4'd1;
              if (settle_q != 2'd0) begin
                state_q <= ST_SETTLE;
              end else begin
                state_q     <= ST_COMPARE;
                comp_trig_q <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sample_en    = sample_en_q;
  assign dac_code     = dac_code_q;
  assign comp_trig    = comp_trig_q;
  assign busy         = busy_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overrun_err  = overrun_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_adc_sar_controller.sv
// Scoreboard bench for adc_sar_controller: directed conversions push the
// hand-computed code and valid cycle; a monitor checks each result_valid.
module tb_adc_sar_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_sample_cycles = 8'd1;
  logic [1:0]  cfg_settle_cycles = 2'd0;
  logic        comp_done = 1'b0;
  logic        comp_result = 1'b0;
  logic        sample_en;
  logic [11:0] dac_code;
  logic        comp_trig;
  logic        busy;
  logic [11:0] result;
  logic        result_valid;
  logic        overrun_err;
  logic        timeout_err;

  adc_sar_controller dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .cfg_sample_cycles (cfg_sample_cycles),
    .cfg_settle_cycles (cfg_settle_cycles),
    .comp_done         (comp_done),
    .comp_result       (comp_result),
    .sample_en         (sample_en),
    .dac_code          (dac_code),
    .comp_trig         (comp_trig),
    .busy              (busy),
    .result            (result),
    .result_valid      (result_valid),
    .overrun_err       (overrun_err),
    .timeout_err       (timeout_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [11:0] code;
    int          vcyc;
  } exp_t;
  exp_t sb[$];

  // Comparator model settings
  logic [11:0] target      = 12'h000;
  logic [11:0] silent_code = 12'h000;
  bit          silent_en   = 1'b0;
  bit          spurious    = 1'b0;
  int          resp_d      = 1;
  int          pend_cnt    = 0;
  logic        pend_res    = 1'b0;
  logic [11:0] trig_log[$];
  int          sample_hi   = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Clocked comparator: answers resp_d cycles after the trigger cycle.
  always @(negedge clk) begin
    comp_done   = 1'b0;
    comp_result = 1'b0;
    if (sample_en) sample_hi++;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        comp_done   = 1'b1;
        comp_result = pend_res;
      end
    end else if (comp_trig) begin
      trig_log.push_back(dac_code);
      if (!(silent_en && dac_code == silent_code)) begin
        pend_cnt = resp_d;
        pend_res = (dac_code <= target);
      end
    end
    if (spurious && !comp_done && pend_cnt == 0 && !comp_trig) begin
      comp_done   = 1'b1;
      comp_result = 1'b1;
    end
  end

  // Monitor: pops the scoreboard on each result_valid pulse.
  always @(negedge clk) begin
    if (result_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_result_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", int'(result), int'(e.code));
        chk("valid_cycle", cyc, e.vcyc);
      end
    end
  end

  task automatic issue(input logic [7:0] s, input logic [1:0] t, input int d,
                       input logic [11:0] tgt, input logic [11:0] exp_code,
                       input int lat);
    exp_t e;
    @(negedge clk);
    cfg_sample_cycles = s;
    cfg_settle_cycles = t;
    resp_d = d;
    target = tgt;
    trig_log.delete();
    sample_hi = 0;
    start = 1'b1;
    e.code = exp_code;
    e.vcyc = cyc + lat;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("conversion_timeout", sb.size(), 0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_sample_en"}, int'(sample_en), 0);
    chk({tag, "_dac_code"}, int'(dac_code), 0);
    chk({tag, "_comp_trig"}, int'(comp_trig), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_result"}, int'(result), 0);
    chk({tag, "_result_valid"}, int'(result_valid), 0);
    chk({tag, "_overrun"}, int'(overrun_err), 0);
    chk({tag, "_timeout"}, int'(timeout_err), 0);
  endtask

  initial begin
    int c0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // 1: target 0xA5C, S=1 T=0 D=1 -> valid 26 cycles after start
    issue(8'd1, 2'd0, 1, 12'hA5C, 12'hA5C, 26);
    chk("busy_after_start", int'(busy), 1);
    wait_done();
    chk("trig0", int'(trig_log[0]), 12'h800);
    chk("trig1", int'(trig_log[1]), 12'hC00);
    chk("trig2", int'(trig_log[2]), 12'hA00);
    chk("trig_count", trig_log.size(), 12);
    chk("s1_timeout", int'(timeout_err), 0);
    chk("s1_busy_idle", int'(busy), 0);
    chk("s1_result_held", int'(result), 12'hA5C);

    // 2: all-ones and all-zeros, S=4 T=2 D=1 -> 53
    issue(8'd4, 2'd2, 1, 12'hFFF, 12'hFFF, 53);
    wait_done();
    chk("s2a_sample_len", sample_hi, 4);
    issue(8'd4, 2'd2, 1, 12'h000, 12'h000, 53);
    wait_done();

    // 3: comparator silent on bit-5 trial -> 0xFDF after forced zero
    silent_en = 1'b1;
    silent_code = 12'hFE0;
    issue(8'd1, 2'd0, 1, 12'hFFF, 12'hFDF, 41);
    wait_done();
    silent_en = 1'b0;
    chk("s3_timeout_err", int'(timeout_err), 1);

    // 4: start re-pulsed in cycle 10 -> overrun, result unaffected
    issue(8'd1, 2'd0, 1, 12'hA5C, 12'hA5C, 26);
    chk("s4_timeout_cleared", int'(timeout_err), 0);
    repeat (8) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("s4_overrun_set", int'(overrun_err), 1);
    wait_done();
    chk("s4_overrun_sticky", int'(overrun_err), 1);

    // 5: rst in cycle 12 aborts; then a fresh conversion
    issue(8'd1, 2'd0, 1, 12'h3C3, 12'h3C3, 26);
    chk("s5_overrun_cleared", int'(overrun_err), 0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());
    chk_reset_outputs("abort");
    repeat (20) @(negedge clk);
    issue(8'd2, 2'd1, 2, 12'h123, 12'h123, 51);
    wait_done();

    // 6: sample length 0 -> 1 cycle; spurious comp_done in SAMPLE/SETTLE
    spurious = 1'b1;
    issue(8'd0, 2'd3, 1, 12'h5A5, 12'h5A5, 62);
    wait_done();
    spurious = 1'b0;
    chk("s6_sample_len", sample_hi, 1);
    c0 = trig_log.size();
    chk("s6_trig_count", c0, 12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
